pwm_apb_master: RTL and testbench

//   APB-lite initiator driving the PWM peripheral's psel/penable/pwrite/paddr/pwdata bus.

---
 rtl/pwm_apb_pkg.sv | 32 +++
 rtl/pwm_apb_master_if.sv | 23 ++
 rtl/pwm_apb_wait_timer.sv | 32 +++
 rtl/pwm_apb_master.sv | 95 +++++++++
 tb/tb_pwm_apb_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_apb_pkg.sv
// Shared types for the PWM APB initiator: FSM state, default-width command/response
// records and the wait-counter width helper.
package pwm_apb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] rdata;
    } apb_rsp_t;

    // TIMEOUT of 0 disables the abort but still needs a 1-bit counter
    function automatic int wait_cnt_width(input int timeout);
        if (timeout < 1) return 1;
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pwm_apb_master_if.sv
// APB bus between the initiator (master) and the PWM peripheral (slave).
interface pwm_apb_master_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [WIDTH-1:0]  pwdata;
    logic [WIDTH-1:0]  prdata;
    logic              pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/pwm_apb_wait_timer.sv
// Counts pready-low ACCESS cycles; expired flags the cycle that would be the TIMEOUT-th one.
module pwm_apb_wait_timer
    import pwm_apb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = wait_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] SAT  = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // Abort is decided in the same cycle the last allowed low-pready sample is seen
    assign expired = (TIMEOUT != 0) && count_en && (count == LAST);

endmodule

// File: rtl/pwm_apb_master.sv
// APB-lite initiator: one valid/ready command in, SETUP/ACCESS on the bus, valid/ready response out.
module pwm_apb_master
    import pwm_apb_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    pwm_apb_master_if.master  apb,
    output logic              busy
);
    apb_state_e state;
    logic       accept;
    logic       wait_en;
    logic       expired;

    assign accept  = (state == ST_IDLE) && cmd_valid;
    assign wait_en = (state == ST_ACCESS) && !apb.pready;

    pwm_apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .count_en (wait_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        apb.pwrite <= cmd_write;
                        apb.paddr  <= cmd_addr;
                        apb.pwdata <= cmd_wdata;
                        apb.psel   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout landing on the same cycle
                    if (apb.pready || expired) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= !apb.pready;
                        rsp_rdata   <= (apb.pready && !apb.pwrite) ? apb.prdata : '0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_apb_master.sv
// Bench for pwm_apb_master with a register-file slave standing in for pwm_top.
module tb_pwm_apb_master;
    import pwm_apb_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    pwm_apb_master_if #(.WIDTH(16), .ADDR_W(4)) apb ();

    pwm_apb_master #(
        .WIDTH   (16),
        .ADDR_W  (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // slave model: registers plus a programmable number of pready-low ACCESS cycles
    logic [15:0] mem [16];
    int          acc_cnt = 0;
    int          stall_n = 0;

    assign apb.prdata = mem[apb.paddr];
    assign apb.pready = (acc_cnt > stall_n);

    always @(negedge clk) begin
        if (apb.psel && apb.penable) acc_cnt = acc_cnt + 1;
        else                         acc_cnt = 0;
    end

    always @(posedge clk) begin
        if (apb.psel && apb.penable && apb.pready && apb.pwrite) mem[apb.paddr] = apb.pwdata;
    end

    int          checks = 0;
    int          failures = 0;
    logic [15:0] ref_regs [16];
    int          lat;
    apb_rsp_t    rsp;
    bit          p_ok, s_ok, h_ok, i_ok;

    // reference timing: SETUP + ACCESS cycles, abort on the TIMEOUT-th low cycle
    function automatic int exp_lat(input int stall);
        if (TIMEOUT != 0 && stall >= TIMEOUT) return TIMEOUT + 2;
        return stall + 3;
    endfunction

    function automatic bit exp_err(input int stall);
        return (TIMEOUT != 0 && stall >= TIMEOUT);
    endfunction

    task automatic drive_cmd(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                             input int stall, input int rstall, output int l, output apb_rsp_t r,
                             output bit phase_ok, output bit stable_ok, output bit hold_ok,
                             output bit idle_ok);
        int e;
        @(negedge clk);
        stall_n   = stall;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        rsp_ready = (rstall == 0);
        l = -1; r = '0;
        phase_ok = 1'b1; stable_ok = 1'b1; hold_ok = 1'b1; idle_ok = 1'b1;
        if (cmd_ready !== 1'b1) phase_ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = addr ^ 4'hF;
        cmd_wdata = ~wdata;
        e = 1;
        while (e <= 300) begin
            if (rsp_valid === 1'b1) begin
                l = e;
                r.err = rsp_err;
                r.rdata = rsp_rdata;
                if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0)
                    phase_ok = 1'b0;
                break;
            end
            if (e == 1) begin
                if (apb.psel !== 1'b1 || apb.penable !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0)
                    phase_ok = 1'b0;
            end else if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin
                phase_ok = 1'b0;
            end
            if (apb.paddr !== addr || apb.pwrite !== wr || apb.pwdata !== wdata) stable_ok = 1'b0;
            @(posedge clk); #1;
            e++;
        end
        if (l < 0) begin
            rsp_ready = 1'b1;
            idle_ok = 1'b0;
            return;
        end
        for (int k = 1; k < rstall; k++) begin
            cmd_valid = 1'b1;
            cmd_write = ~wr;
            cmd_addr  = addr ^ 4'h5;
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r.rdata || rsp_err !== r.err ||
                cmd_ready !== 1'b0 || apb.psel !== 1'b0)
                hold_ok = 1'b0;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || apb.psel !== 1'b0 ||
            apb.paddr !== addr || apb.pwrite !== wr || apb.pwdata !== wdata)
            idle_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; stall_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_busy: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
        checks++;
        if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || apb.pwrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_apb_ctrl: psel=%b penable=%b pwrite=%b required 0/0/0",
                     apb.psel, apb.penable, apb.pwrite);
        end
        checks++;
        if (apb.paddr !== 4'h0 || apb.pwdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_apb_data: paddr=%h pwdata=%h required 0/0", apb.paddr, apb.pwdata);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b required 0/0/0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_basic();
        drive_cmd(1'b1, 4'h2, 16'h1234, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
        ref_regs[2] = 16'h1234;
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL write_latency: got %0d required 3", lat);
        end
        checks++;
        if (rsp.err !== 1'b0 || rsp.rdata !== 16'h0) begin
            failures++;
            $display("FAIL write_rsp: err=%b rdata=%h required 0/0", rsp.err, rsp.rdata);
        end
        checks++;
        if (p_ok !== 1'b1 || s_ok !== 1'b1 || i_ok !== 1'b1) begin
            failures++;
            $display("FAIL write_phases: phase=%b stable=%b idle=%b required 1/1/1", p_ok, s_ok, i_ok);
        end
    endtask

    task automatic test_back_to_back();
        apb_cmd_t cmds [4];
        for (int k = 0; k < 4; k++) begin
            cmds[k].write = 1'b1;
            cmds[k].addr  = 4'(k);
            cmds[k].wdata = 16'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            drive_cmd(cmds[k].write, cmds[k].addr, cmds[k].wdata, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            ref_regs[k] = cmds[k].wdata;
            checks++;
            if (lat !== 3 || rsp.err !== 1'b0 || p_ok !== 1'b1 || s_ok !== 1'b1 || i_ok !== 1'b1) begin
                failures++;
                $display("FAIL b2b_write%0d: lat=%0d err=%b phase=%b stable=%b idle=%b required 3/0/1/1/1",
                         k, lat, rsp.err, p_ok, s_ok, i_ok);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive_cmd(1'b0, 4'(k), 16'($urandom), 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            checks++;
            if (rsp.rdata !== ref_regs[k] || rsp.err !== 1'b0 || lat !== 3) begin
                failures++;
                $display("FAIL b2b_readback%0d: rdata=%h err=%b lat=%0d required %h/0/3",
                         k, rsp.rdata, rsp.err, lat, ref_regs[k]);
            end
        end
    endtask

    task automatic test_read_wait();
        drive_cmd(1'b1, 4'h3, 16'hBEEF, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
        ref_regs[3] = 16'hBEEF;
        drive_cmd(1'b0, 4'h3, 16'h5A5A, 3, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
        checks++;
        if (lat !== exp_lat(3)) begin
            failures++;
            $display("FAIL read_wait_latency: got %0d required %0d", lat, exp_lat(3));
        end
        checks++;
        if (rsp.rdata !== ref_regs[3] || rsp.err !== 1'b0) begin
            failures++;
            $display("FAIL read_wait_data: rdata=%h err=%b required %h/0", rsp.rdata, rsp.err, ref_regs[3]);
        end
        checks++;
        if (s_ok !== 1'b1 || p_ok !== 1'b1) begin
            failures++;
            $display("FAIL read_wait_stable: stable=%b phase=%b required 1/1", s_ok, p_ok);
        end
    endtask

    task automatic test_timeout();
        int stalls [3] = '{1000, TIMEOUT, TIMEOUT - 1};
        for (int k = 0; k < 3; k++) begin
            drive_cmd(1'b0, 4'h3, 16'h0, stalls[k], 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            checks++;
            if (lat !== exp_lat(stalls[k]) || rsp.err !== exp_err(stalls[k])) begin
                failures++;
                $display("FAIL timeout_stall%0d: lat=%0d err=%b required %0d/%b",
                         stalls[k], lat, rsp.err, exp_lat(stalls[k]), exp_err(stalls[k]));
            end
            checks++;
            if (rsp.rdata !== (exp_err(stalls[k]) ? 16'h0 : ref_regs[3]) || p_ok !== 1'b1 || i_ok !== 1'b1) begin
                failures++;
                $display("FAIL timeout_rsp%0d: rdata=%h phase=%b idle=%b required %h/1/1", stalls[k],
                         rsp.rdata, p_ok, i_ok, exp_err(stalls[k]) ? 16'h0 : ref_regs[3]);
            end
        end
    endtask

    task automatic test_rsp_stall();
        drive_cmd(1'b0, 4'h2, 16'h0, 1, 5, lat, rsp, p_ok, s_ok, h_ok, i_ok);
        checks++;
        if (h_ok !== 1'b1 || rsp.rdata !== ref_regs[2]) begin
            failures++;
            $display("FAIL rsp_stall_hold: hold=%b rdata=%h required 1/%h", h_ok, rsp.rdata, ref_regs[2]);
        end
        checks++;
        if (i_ok !== 1'b1 || lat !== exp_lat(1)) begin
            failures++;
            $display("FAIL rsp_stall_ignore: idle=%b lat=%0d required 1/%0d", i_ok, lat, exp_lat(1));
        end
    endtask

    task automatic test_reset_mid();
        bit seen_valid;
        int k;
        @(negedge clk);
        stall_n = 1000;
        cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 16'hDEAD; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (apb.penable !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (apb.penable !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_access: penable=%b required 1", apb.penable);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: psel=%b penable=%b required 0/0", apb.psel, apb.penable);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall_n = 0;
        seen_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp: stray activity=%b required 0", seen_valid);
        end
        drive_cmd(1'b0, 4'h2, 16'h0, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
        checks++;
        if (lat !== 3 || rsp.rdata !== ref_regs[2] || rsp.err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_next: lat=%0d rdata=%h err=%b required 3/%h/0",
                     lat, rsp.rdata, rsp.err, ref_regs[2]);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] want;
        int          stall, rstall;
        for (int a = 0; a < 16; a++) begin
            wdata = 16'($urandom);
            drive_cmd(1'b1, 4'(a), wdata, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            ref_regs[a] = wdata;
        end
        for (int n = 0; n < 24; n++) begin
            wr     = 1'($urandom_range(0, 1));
            addr   = 4'($urandom_range(0, 15));
            wdata  = 16'($urandom);
            stall  = $urandom_range(0, TIMEOUT + 2);
            rstall = $urandom_range(0, 3);
            drive_cmd(wr, addr, wdata, stall, rstall, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            want = (exp_err(stall) || wr) ? 16'h0 : ref_regs[addr];
            if (wr && !exp_err(stall)) ref_regs[addr] = wdata;
            checks++;
            if (lat !== exp_lat(stall) || rsp.err !== exp_err(stall) || rsp.rdata !== want) begin
                failures++;
                $display("FAIL random%0d: lat=%0d err=%b rdata=%h required %0d/%b/%h",
                         n, lat, rsp.err, rsp.rdata, exp_lat(stall), exp_err(stall), want);
            end
            checks++;
            if (p_ok !== 1'b1 || s_ok !== 1'b1 || h_ok !== 1'b1 || i_ok !== 1'b1) begin
                failures++;
                $display("FAIL random%0d_protocol: phase=%b stable=%b hold=%b idle=%b required 1/1/1/1",
                         n, p_ok, s_ok, h_ok, i_ok);
            end
        end
        for (int a = 0; a < 16; a++) begin
            drive_cmd(1'b0, 4'(a), 16'h0, 0, 0, lat, rsp, p_ok, s_ok, h_ok, i_ok);
            checks++;
            if (rsp.rdata !== ref_regs[a]) begin
                failures++;
                $display("FAIL random_final%0d: rdata=%h required %h", a, rsp.rdata, ref_regs[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_back_to_back();
        test_read_wait();
        test_timeout();
        test_rsp_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
